// File: rtl/mem_write_monitor_pkg.sv
// mem_write_monitor_pkg: FSM state and failure-code types shared by the store monitor.
package mem_write_monitor_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;
    typedef enum logic [1:0] {NONE = 2'd0, DATA_MISMATCH = 2'd1, TIMEOUT = 2'd2} fail_code_t;
endpackage

// File: rtl/mem_write_monitor_match_sel.sv
// mwm_match_sel: picks the lowest full-match entry and flags any address-only hit.
module mwm_match_sel #(
    parameter int NUM_CHECKS = 4
) (
    input  logic [NUM_CHECKS-1:0] hit,
    input  logic [NUM_CHECKS-1:0] addr_hit,
    output logic [NUM_CHECKS-1:0] first,
    output logic                  any_hit,
    output logic                  any_addr
);
    assign first    = hit & (~hit + NUM_CHECKS'(1));
    assign any_hit  = |hit;
    assign any_addr = |addr_hit;
endmodule

// File: rtl/mem_write_monitor.sv
// mem_write_monitor: checks observed stores against a programmed table of expected stores.
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter int NUM_CHECKS     = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ORDERED        = 1,
    localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1,
    localparam int CW = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic              clear,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              armed,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CW-1:0]     match_count
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    state_t            state;
    fail_code_t        code_q;
    logic [ADDR_W-1:0] exp_addr [NUM_CHECKS];
    logic [DATA_W-1:0] exp_data [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] mask, elig, hit, addr_hit, first;
    logic [TW-1:0]     tcnt;
    logic              any_hit, any_addr, done, tmo, mismatch;
    // In ordered mode only the entry at the pointer (match_count) is eligible,
    // so both modes share the same hit/mismatch decision.
    always_comb begin
        elig     = '0;
        addr_hit = '0;
        hit      = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            elig[i]     = ORDERED != 0 ? match_count == CW'(i) : !mask[i];
            addr_hit[i] = elig[i] && data_adr == exp_addr[i];
            hit[i]      = addr_hit[i] && write_data == exp_data[i];
        end
    end
    mwm_match_sel #(.NUM_CHECKS(NUM_CHECKS)) u_sel (
        .hit(hit),
        .addr_hit(addr_hit),
        .first(first),
        .any_hit(any_hit),
        .any_addr(any_addr)
    );
    assign done      = mem_write && any_hit && match_count == CW'(NUM_CHECKS - 1);
    assign mismatch  = mem_write && any_addr && !any_hit;
    assign tmo       = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign armed     = state == ARMED;
    assign pass      = state == PASS;
    assign fail      = state == FAIL;
    assign fail_code = code_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_addr[i] <= '0;
                exp_data[i] <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (cfg_idx == IW'(i)) begin
                    exp_addr[i] <= cfg_addr;
                    exp_data[i] <= cfg_data;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            code_q      <= NONE;
            match_count <= '0;
            mask        <= '0;
            tcnt        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= ARMED;
                    code_q      <= NONE;
                    match_count <= '0;
                    mask        <= '0;
                    tcnt        <= '0;
                end
                ARMED: begin
                    tcnt <= tmo ? tcnt : tcnt + TW'(1);
                    if (mem_write && any_hit) begin
                        match_count <= match_count + CW'(1);
                        mask        <= mask | first;
                    end
                    if (done) state <= PASS;
                    else if (mismatch) begin
                        state  <= FAIL;
                        code_q <= DATA_MISMATCH;
                    end else if (tmo) begin
                        state  <= FAIL;
                        code_q <= TIMEOUT;
                    end
                end
                default: if (clear) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor: scoreboard bench driving three monitor variants from shared stimulus.
module tb_mem_write_monitor;
    typedef struct {
        string nm;
        int    d, a, p, f, c, n;
    } exp_t;
    localparam logic [31:0] K = 32'hABCDE02E;
    logic        clk = 0, reset = 0;
    logic        cfg_we = 0, start = 0, clear = 0, mem_write = 0;
    logic [0:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0, cfg_data = '0, data_adr = '0, write_data = '0;
    logic        arm [3], pas [3], fal [3];
    logic [1:0]  fc [3];
    logic [0:0]  mc0;
    logic [1:0]  mc1, mc2;
    exp_t        q [$];
    int          nvec = 0, nbad = 0;

    always #5 clk = ~clk;

    mem_write_monitor #(.NUM_CHECKS(1), .TIMEOUT_CYCLES(16), .ORDERED(1)) u_d0 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .clear(clear), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .armed(arm[0]), .pass(pas[0]),
        .fail(fal[0]), .fail_code(fc[0]), .match_count(mc0));
    mem_write_monitor #(.NUM_CHECKS(2), .TIMEOUT_CYCLES(16), .ORDERED(1)) u_d1 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .clear(clear), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .armed(arm[1]), .pass(pas[1]),
        .fail(fal[1]), .fail_code(fc[1]), .match_count(mc1));
    mem_write_monitor #(.NUM_CHECKS(2), .TIMEOUT_CYCLES(16), .ORDERED(0)) u_d2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .clear(clear), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .armed(arm[2]), .pass(pas[2]),
        .fail(fal[2]), .fail_code(fc[2]), .match_count(mc2));

    task automatic chk(input string tag, input int got, input int want);
        nvec++;
        if (got != want) begin
            nbad++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic push(input string nm, input int d, a, p, f, c, n);
        exp_t e;
        e.nm = nm; e.d = d; e.a = a; e.p = p; e.f = f; e.c = c; e.n = n;
        q.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".armed"}, int'(arm[e.d]), e.a);
            chk({e.nm, ".pass"}, int'(pas[e.d]), e.p);
            chk({e.nm, ".fail"}, int'(fal[e.d]), e.f);
            chk({e.nm, ".code"}, int'(fc[e.d]), e.c);
            chk({e.nm, ".count"}, e.d == 0 ? int'(mc0) : e.d == 1 ? int'(mc1) : int'(mc2), e.n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cfg_we = 0; start = 0; clear = 0; mem_write = 0;
        check_now();
    endtask

    task automatic do_reset(input string nm);
        reset = 0;
        #1;
        for (int d = 0; d < 3; d++) push(nm, d, 0, 0, 0, 0, 0);
        check_now();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] v);
        cfg_we = 1; cfg_idx = 1'(idx); cfg_addr = a; cfg_data = v;
        step();
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] v);
        mem_write = 1; data_adr = a; write_data = v;
    endtask

    initial begin
        do_reset("rst");
        // single-entry ordered pass
        cfg(0, 132, K);
        start = 1; push("one_arm", 0, 1, 0, 0, 0, 0); step();
        st(132, K); push("one_pass", 0, 0, 1, 0, 0, 1); step();
        push("one_hold", 0, 0, 1, 0, 0, 1); step();
        // two-entry table seen by ordered (d1) and any-order (d2) monitors
        do_reset("rst2");
        cfg(0, 100, 7); cfg(1, 104, 9);
        start = 1; push("ord_arm", 1, 1, 0, 0, 0, 0); push("any_arm", 2, 1, 0, 0, 0, 0); step();
        st(104, 9); push("ord_s1", 1, 1, 0, 0, 0, 0); push("any_s1", 2, 1, 0, 0, 0, 1); step();
        st(104, 0); push("ord_s2", 1, 1, 0, 0, 0, 0); push("any_matched", 2, 1, 0, 0, 0, 1); step();
        st(200, 5); push("ord_s3", 1, 1, 0, 0, 0, 0); push("any_other", 2, 1, 0, 0, 0, 1); step();
        cfg_we = 1; cfg_idx = 1; cfg_addr = 104; cfg_data = 99;
        push("ord_cfg", 1, 1, 0, 0, 0, 0); push("any_cfg", 2, 1, 0, 0, 0, 1); step();
        st(100, 7); push("ord_s4", 1, 1, 0, 0, 0, 1); push("any_pass", 2, 0, 1, 0, 0, 2); step();
        st(104, 9); push("ord_pass", 1, 0, 1, 0, 0, 2); push("any_hold", 2, 0, 1, 0, 0, 2); step();
        start = 1; push("ord_hold", 1, 0, 1, 0, 0, 2); step();
        clear = 1; step();
        start = 1; push("ord_rearm", 1, 1, 0, 0, 0, 0); push("any_rearm", 2, 1, 0, 0, 0, 0); step();
        st(100, 7); push("ord_r1", 1, 1, 0, 0, 0, 1); push("any_r1", 2, 1, 0, 0, 0, 1); step();
        st(104, 9); push("ord_r2", 1, 0, 1, 0, 0, 2); push("any_r2", 2, 0, 1, 0, 0, 2); step();
        // data mismatch on every variant
        do_reset("rst3");
        cfg(0, 132, K);
        start = 1; step();
        st(132, 0);
        for (int d = 0; d < 3; d++) push("mis", d, 0, 0, 1, 1, 0);
        step();
        push("mis_hold", 0, 0, 0, 1, 1, 0); step();
        // timeout, completion on the timeout cycle, mismatch on the timeout cycle
        for (int v = 0; v < 3; v++) begin
            do_reset("rst4");
            cfg(0, 132, K);
            start = 1; push("to_arm", 0, 1, 0, 0, 0, 0); step();
            for (int k = 1; k < 16; k++) begin
                push("to_wait", 0, 1, 0, 0, 0, 0);
                step();
            end
            if (v == 1) st(132, K);
            if (v == 2) st(132, 0);
            case (v)
                0: push("to_fail", 0, 0, 0, 1, 2, 0);
                1: push("to_pass", 0, 0, 1, 0, 0, 1);
                default: push("to_mis", 0, 0, 0, 1, 1, 0);
            endcase
            step();
        end
        // reset in the middle of an armed check
        do_reset("rst5");
        cfg(0, 100, 7); cfg(1, 104, 9);
        start = 1; step();
        st(100, 7); push("mid_cnt", 1, 1, 0, 0, 0, 1); step();
        do_reset("mid_rst");
        start = 1; push("mid_rearm", 1, 1, 0, 0, 0, 0); step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
